// File: rtl/io_bus_initiator_if.sv
// General-purpose IO bus between an initiator (master) and a responder (slave).
interface io_bus_initiator_if;
  logic        IO_RD;
  logic        IO_WR;
  logic [31:0] IO_A;
  logic [3:0]  IO_BE;
  logic [31:0] IO_DI;
  logic [31:0] IO_Q;
  logic        IO_READY;

  modport master (output IO_RD, IO_WR, IO_A, IO_BE, IO_DI, input  IO_Q, IO_READY);
  modport slave  (input  IO_RD, IO_WR, IO_A, IO_BE, IO_DI, output IO_Q, IO_READY);
endinterface

// File: rtl/io_bus_initiator.sv
// IO bus initiator: one bus cycle per byte/halfword/word command, with
// byte enables, write lane replication, LSB-aligned read data and a wait timeout.
module io_bus_initiator #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  io_bus_initiator_if.master bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  state_t           state_q, state_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  rsp_t             rsp_q, rsp_d;
  logic             io_rd_q, io_rd_d;
  logic             io_wr_q, io_wr_d;
  logic [31:0]      io_a_q, io_a_d;
  logic [3:0]       io_be_q, io_be_d;
  logic [31:0]      io_di_q, io_di_d;
  logic [1:0]       size_q, size_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        hs, legal, done, tmo;
  logic [3:0]  be_w;
  logic [31:0] di_w, rdata_al;

  assign hs   = (state_q == IDLE) & req_ready_q & req_valid;
  assign done = (state_q == ACCESS) & bus.IO_READY & (io_rd_q | io_wr_q);
  // IO_READY takes priority over a timeout landing on the same cycle
  assign tmo  = (state_q == ACCESS) & ~bus.IO_READY & (TIMEOUT_CYCLES != 0) & (cnt_q == TMO);

  always_comb begin
    legal = 1'b0;
    be_w  = 4'hF;
    di_w  = req_wdata;
    case (req_size)
      2'b00: begin
        legal = 1'b1;
        be_w  = 4'b0001 << req_addr[1:0];
        di_w  = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        legal = ~req_addr[0];
        be_w  = req_addr[1] ? 4'b1100 : 4'b0011;
        di_w  = {2{req_wdata[15:0]}};
      end
      2'b10:   legal = (req_addr[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    case (size_q)
      2'b00:   rdata_al = {24'h0, bus.IO_Q[{io_a_q[1:0], 3'b000} +: 8]};
      2'b01:   rdata_al = {16'h0, io_a_q[1] ? bus.IO_Q[31:16] : bus.IO_Q[15:0]};
      default: rdata_al = bus.IO_Q;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      io_rd_q     <= 1'b0;
      io_wr_q     <= 1'b0;
      io_a_q      <= '0;
      io_be_q     <= '0;
      io_di_q     <= '0;
      size_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
      io_rd_q     <= io_rd_d;
      io_wr_q     <= io_wr_d;
      io_a_q      <= io_a_d;
      io_be_q     <= io_be_d;
      io_di_q     <= io_di_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs) state_d = legal ? ACCESS : RESP;
      ACCESS:  if (done || tmo) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // registered outputs
  always_comb begin
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    rsp_d       = rsp_q;
    io_rd_d     = io_rd_q;
    io_wr_d     = io_wr_q;
    io_a_d      = io_a_q;
    io_be_d     = io_be_q;
    io_di_d     = io_di_q;
    size_d      = size_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: if (hs) begin
        if (legal) begin
          io_rd_d = ~req_wr;
          io_wr_d = req_wr;
          io_a_d  = {8'h00, req_addr};
          io_be_d = be_w;
          if (req_wr) io_di_d = di_w;
          size_d  = req_size;
          cnt_d   = '0;
        end else begin
          rsp_d = '{err: 1'b1, rdata: 32'h0};
        end
      end
      ACCESS: begin
        if (done) begin
          io_rd_d = 1'b0;
          io_wr_d = 1'b0;
          rsp_d   = '{err: 1'b0, rdata: io_wr_q ? 32'h0 : rdata_al};
        end else if (tmo) begin
          io_rd_d = 1'b0;
          io_wr_d = 1'b0;
          rsp_d   = '{err: 1'b1, rdata: 32'h0};
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_q.rdata;
  assign rsp_err    = rsp_q.err;
  assign bus.IO_RD  = io_rd_q;
  assign bus.IO_WR  = io_wr_q;
  assign bus.IO_A   = io_a_q;
  assign bus.IO_BE  = io_be_q;
  assign bus.IO_DI  = io_di_q;
endmodule
